// File: rtl/aquarium_scan_ctrl_pkg.sv
// aq_pkg: select codes, channel indices and state type shared by the aquarium scan controller
package aq_pkg;
   localparam logic [4:0] SEL_IDLE  = 5'b00000;
   localparam logic [4:0] SEL_COUNT = 5'b00001;
   localparam logic [4:0] SEL_CLEAN = 5'b00010;
   localparam logic [4:0] SEL_TEMP  = 5'b00100;
   localparam logic [4:0] SEL_FOOD  = 5'b01000;
   localparam logic [4:0] SEL_SALT  = 5'b10000;
   localparam logic [4:0] SAL_SALT  = SEL_SALT;
   localparam logic [4:0] SEL_ERR   = 5'b11111;
   localparam logic [1:0] CH_CLEAN  = 2'd0;
   localparam logic [1:0] CH_TEMP   = 2'd1;
   localparam logic [1:0] CH_FOOD   = 2'd2;
   localparam logic [1:0] CH_SALT   = 2'd3;
   typedef enum logic [4:0] {
      ST_IDLE  = SEL_IDLE,
      ST_COUNT = SEL_COUNT,
      ST_CLEAN = SEL_CLEAN,
      ST_TEMP  = SEL_TEMP,
      ST_FOOD  = SEL_FOOD,
      ST_SALT  = SEL_SALT,
      ST_ERR   = SEL_ERR
   } state_t;
endpackage

// File: rtl/aq_threshold_check.sv
// aq_threshold_check: flags a sensor value outside its acceptable range for the given channel
module aq_threshold_check
   import aq_pkg::*;
#(
   parameter logic [7:0] CLEAN_MIN = 8'd64,
   parameter logic [7:0] TEMP_MIN  = 8'd70,
   parameter logic [7:0] TEMP_MAX  = 8'd90,
   parameter logic [7:0] FOOD_MIN  = 8'd32,
   parameter logic [7:0] SALT_MAX  = 8'd200
) (
   input  logic [1:0] ch,
   input  logic [7:0] value,
   output logic       fault
);
   // range test selected by channel
   always_comb
      fault = ch == CH_CLEAN ? value < CLEAN_MIN :
              ch == CH_TEMP  ? (value < TEMP_MIN || value > TEMP_MAX) :
              ch == CH_FOOD  ? value < FOOD_MIN : value > SALT_MAX;
endmodule

// File: rtl/aquarium_scan_ctrl.sv
// aquarium_scan_ctrl: tank mux sequencer with threshold checking and error lockout
// Define AQ_STICKY_FAULT_EN to OR-accumulate ch_fault across scans until clear_err/reset.
module aquarium_scan_ctrl
   import aq_pkg::*;
#(
   parameter logic [7:0] CLEAN_MIN = 8'd64,
   parameter logic [7:0] TEMP_MIN  = 8'd70,
   parameter logic [7:0] TEMP_MAX  = 8'd90,
   parameter logic [7:0] FOOD_MIN  = 8'd32,
   parameter logic [7:0] SALT_MAX  = 8'd200,
   parameter int         ERR_LIMIT = 3
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       start,
   input  logic       clear_err,
   input  logic [7:0] q_clean,
   input  logic [7:0] q_temp,
   input  logic [7:0] q_food,
   input  logic [7:0] q_salt,
   output logic [4:0] sel,
   output logic [7:0] sample,
   output logic       sample_valid,
   output logic [1:0] sample_ch,
   output logic [3:0] ch_fault,
   output logic [7:0] scan_count,
   output logic       busy,
   output logic       error
);
   localparam logic [3:0] LIM = 4'(ERR_LIMIT);
   state_t     state, nxt;
   logic [3:0] pending, pend_all, streak, streak_next;
   logic [1:0] cur_ch;
   logic [7:0] cur_val;
   logic       fault, sensing;
   assign sel = state;
   aq_threshold_check #(
      .CLEAN_MIN(CLEAN_MIN), .TEMP_MIN(TEMP_MIN), .TEMP_MAX(TEMP_MAX),
      .FOOD_MIN(FOOD_MIN), .SALT_MAX(SALT_MAX)
   ) u_chk (.ch(cur_ch), .value(cur_val), .fault(fault));
   // channel being visited, end-of-scan fault summary and next state
   always_comb begin
      sensing     = state inside {ST_CLEAN, ST_TEMP, ST_FOOD, ST_SALT};
      cur_ch      = state == ST_TEMP ? CH_TEMP : state == ST_FOOD ? CH_FOOD :
                    state == ST_SALT ? CH_SALT : CH_CLEAN;
      cur_val     = state == ST_TEMP ? q_temp : state == ST_FOOD ? q_food :
                    state == ST_SALT ? q_salt : q_clean;
      pend_all    = {fault, pending[2:0]};
      streak_next = |pend_all ? (streak == 4'hf ? streak : streak + 4'd1) : 4'd0;
      case (state)
         ST_IDLE:  nxt = start ? ST_COUNT : ST_IDLE;
         ST_COUNT: nxt = ST_CLEAN;
         ST_CLEAN: nxt = ST_TEMP;
         ST_TEMP:  nxt = ST_FOOD;
         ST_FOOD:  nxt = ST_SALT;
         ST_SALT:  nxt = !clear_err && streak_next >= LIM ? ST_ERR :
                         start ? ST_COUNT : ST_IDLE;
         ST_ERR:   nxt = clear_err ? ST_IDLE : ST_ERR;
         default:  nxt = ST_IDLE;
      endcase
   end
   // state/select register, sample capture and end-of-scan bookkeeping
   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= ST_IDLE;
         sample       <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         ch_fault     <= '0;
         scan_count   <= '0;
         pending      <= '0;
         streak       <= '0;
         busy         <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= nxt;
         busy         <= nxt != ST_IDLE && nxt != ST_ERR;
         error        <= nxt == ST_ERR;
         sample_valid <= sensing;
         if (sensing) begin
            sample    <= cur_val;
            sample_ch <= cur_ch;
         end
         if (state == ST_SALT) begin
            scan_count <= scan_count + 8'd1;
            pending    <= '0;
            if (clear_err) begin
               streak   <= '0;
               ch_fault <= '0;
            end else begin
               streak   <= streak_next;
`ifdef AQ_STICKY_FAULT_EN
               ch_fault <= ch_fault | pend_all;
`else
               ch_fault <= pend_all;
`endif
            end
         end else begin
            if (sensing)
               pending[cur_ch] <= fault;
            if (clear_err) begin
               streak   <= '0;
               ch_fault <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_aquarium_scan_ctrl.sv
// tb_aquarium_scan_ctrl: table-driven and directed checks of the aquarium scan controller
module tb_aquarium_scan_ctrl;
   logic       CLK, reset, start, clear_err;
   logic [7:0] q_clean, q_temp, q_food, q_salt;
   logic [4:0] sel;
   logic [7:0] sample, scan_count;
   logic       sample_valid, busy, error;
   logic [1:0] sample_ch;
   logic [3:0] ch_fault;
   int         passed = 0, total = 0;

   typedef struct {
      logic       start, clr;
      logic [7:0] clean, temp, food, salt;
      logic [4:0] sel;
      logic       sv;
      logic [7:0] smp;
      logic [1:0] ch;
      logic [3:0] flt;
      logic [7:0] cnt;
      logic       busy, err;
   } vec_t;
   vec_t tbl[7];

   aquarium_scan_ctrl dut (
      .CLK(CLK), .reset(reset), .start(start), .clear_err(clear_err),
      .q_clean(q_clean), .q_temp(q_temp), .q_food(q_food), .q_salt(q_salt),
      .sel(sel), .sample(sample), .sample_valid(sample_valid), .sample_ch(sample_ch),
      .ch_fault(ch_fault), .scan_count(scan_count), .busy(busy), .error(error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; clear_err = 1'b0;
      steps(2);
      reset = 1'b0;
   endtask

   task automatic set_q(input logic [7:0] c, input logic [7:0] t, input logic [7:0] f, input logic [7:0] s);
      q_clean = c; q_temp = t; q_food = f; q_salt = s;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b00001, 1'b0, 8'd0,   2'd0, 4'b0000, 8'd0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b00010, 1'b0, 8'd0,   2'd0, 4'b0000, 8'd0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b00100, 1'b1, 8'd100, 2'd0, 4'b0000, 8'd0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b01000, 1'b1, 8'd80,  2'd1, 4'b0000, 8'd0, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b10000, 1'b1, 8'd50,  2'd2, 4'b0000, 8'd0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b00000, 1'b1, 8'd150, 2'd3, 4'b0000, 8'd1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 8'd100, 8'd80, 8'd50, 8'd150, 5'b00000, 1'b0, 8'd150, 2'd3, 4'b0000, 8'd1, 1'b0, 1'b0};
      set_q(8'd100, 8'd80, 8'd50, 8'd150);
      do_reset();
      chk("reset_sel", sel, 5'b00000);
      chk("reset_sample", sample, 8'd0);
      chk("reset_valid", sample_valid, 1'b0);
      chk("reset_ch", sample_ch, 2'd0);
      chk("reset_fault", ch_fault, 4'd0);
      chk("reset_count", scan_count, 8'd0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_error", error, 1'b0);

      // single scan, all channels in range
      for (int i = 0; i < 7; i++) begin
         start = tbl[i].start; clear_err = tbl[i].clr;
         set_q(tbl[i].clean, tbl[i].temp, tbl[i].food, tbl[i].salt);
         steps(1);
         chk($sformatf("v%0d_sel", i), sel, tbl[i].sel);
         chk($sformatf("v%0d_valid", i), sample_valid, tbl[i].sv);
         chk($sformatf("v%0d_sample", i), sample, tbl[i].smp);
         chk($sformatf("v%0d_ch", i), sample_ch, tbl[i].ch);
         chk($sformatf("v%0d_fault", i), ch_fault, tbl[i].flt);
         chk($sformatf("v%0d_count", i), scan_count, tbl[i].cnt);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("v%0d_error", i), error, tbl[i].err);
      end

      // three failing temp scans in continuous mode lock into ERROR
      do_reset();
      set_q(8'd100, 8'd95, 8'd50, 8'd150);
      start = 1'b1;
      steps(6);
      chk("temp_s1_fault", ch_fault, 4'b0010);
      chk("temp_s1_sel", sel, 5'b00001);
      steps(10);
      chk("temp_s3_sel", sel, 5'b11111);
      chk("temp_s3_error", error, 1'b1);
      chk("temp_s3_busy", busy, 1'b0);
      chk("temp_s3_count", scan_count, 8'd3);
      steps(2);
      chk("err_hold_sel", sel, 5'b11111);
      clear_err = 1'b1;
      steps(1);
      clear_err = 1'b0;
      chk("clr_sel", sel, 5'b00000);
      chk("clr_error", error, 1'b0);
      chk("clr_fault", ch_fault, 4'b0000);
      q_temp = 8'd80;
      steps(1);
      start = 1'b0;
      steps(5);
      chk("post_clr_sel", sel, 5'b00000);
      chk("post_clr_count", scan_count, 8'd4);
      chk("post_clr_fault", ch_fault, 4'b0000);

      // passing scan resets the streak
      q_salt = 8'd210; start = 1'b1;
      steps(6);
      chk("salt_s1_fault", ch_fault, 4'b1000);
      steps(5);
      q_salt = 8'd150;
      steps(5);
      chk("salt_pass_fault", ch_fault, 4'b0000);
      q_salt = 8'd210;
      steps(10);
      chk("salt_s5_sel", sel, 5'b00001);
      chk("salt_s5_error", error, 1'b0);
      chk("salt_s5_fault", ch_fault, 4'b1000);
      start = 1'b0;
      steps(5);
      chk("salt_s6_sel", sel, 5'b11111);
      clear_err = 1'b1;
      steps(1);
      clear_err = 1'b0;
      chk("salt_clr_sel", sel, 5'b00000);

      // clear_err on the SALT exit edge overrides faults but still counts
      start = 1'b1;
      steps(1);
      start = 1'b0;
      steps(4);
      chk("edge_clr_in_salt", sel, 5'b10000);
      clear_err = 1'b1;
      steps(1);
      clear_err = 1'b0;
      chk("edge_clr_fault", ch_fault, 4'b0000);
      chk("edge_clr_count", scan_count, 8'd11);
      chk("edge_clr_sel", sel, 5'b00000);

      // reset in TEMP discards the partial scan
      set_q(8'd10, 8'd80, 8'd50, 8'd150);
      start = 1'b1;
      steps(1);
      start = 1'b0;
      steps(2);
      chk("mid_sel_temp", sel, 5'b00100);
      reset = 1'b1;
      steps(1);
      reset = 1'b0;
      chk("mid_rst_sel", sel, 5'b00000);
      chk("mid_rst_valid", sample_valid, 1'b0);
      chk("mid_rst_count", scan_count, 8'd0);
      q_clean = 8'd100;
      start = 1'b1;
      steps(1);
      start = 1'b0;
      steps(5);
      chk("after_rst_fault", ch_fault, 4'b0000);
      chk("after_rst_count", scan_count, 8'd1);
      chk("after_rst_sel", sel, 5'b00000);

      // 256 continuous scans wrap the counter
      do_reset();
      start = 1'b1;
      steps(1 + 255 * 5);
      chk("wrap_255", scan_count, 8'd255);
      steps(5);
      chk("wrap_0", scan_count, 8'd0);
      chk("wrap_sel", sel, 5'b00001);
      q_food = 8'd10;
      steps(5);
      chk("food_fault", ch_fault, 4'b0100);
      q_food = 8'd50;
      steps(5);
`ifdef AQ_STICKY_FAULT_EN
      chk("food_after_good", ch_fault, 4'b0100);
`else
      chk("food_after_good", ch_fault, 4'b0000);
`endif
      start = 1'b0;
      steps(5);
      chk("final_idle", sel, 5'b00000);
      clear_err = 1'b1;
      steps(1);
      clear_err = 1'b0;
      chk("final_clr_fault", ch_fault, 4'b0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
